// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump target adder and a
// shift-add multiplier that freezes the front end while it iterates.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_e,
  input  logic            reg_write_en_e,
  input  logic [4:0]      reg_write_addr_e,
  input  logic [4:0]      reg_read_addr1_e,
  input  logic [4:0]      reg_read_addr2_e,
  input  logic [XLEN-1:0] reg_readdata1_e,
  input  logic [XLEN-1:0] reg_readdata2_e,
  input  logic [XLEN-1:0] imm_data_e,
  input  logic            alu_en_e,
  input  logic [4:0]      alu_op_e,
  input  logic            alu_mul_data2_sel_e,
  input  logic            mul_en_e,
  input  logic            pcadder_in1_sel_e,
  input  logic            pcadder_in2_sel_e,
  input  logic            pcadder_out_sel_e,
  input  logic            pcadder_out_merge_sel_e,
  input  logic [1:0]      execute_out_sel_e,
  input  logic            fwd_mem_en,
  input  logic [4:0]      fwd_mem_addr,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_en,
  input  logic [4:0]      fwd_wb_addr,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic [XLEN-1:0] ex_result_x,
  output logic [XLEN-1:0] store_data_x,
  output logic            reg_write_en_x,
  output logic [4:0]      reg_write_addr_x,
  output logic            redirect_x,
  output logic [XLEN-1:0] redirect_pc_x,
  output logic            stall_x
);

  localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic                sign_q, sign_d;
  logic [1:0]          var_q, var_d;

  logic [XLEN-1:0]     fwd_a, fwd_b, op_a, op_b;
  logic [XLEN-1:0]     alu_res, mul_res, pc_sum;
  logic [2*XLEN-1:0]   prod;
  logic                cond, a_signed, b_signed;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] src, input logic [XLEN-1:0] rf,
                                               input logic me, input logic [4:0] ma,
                                               input logic [XLEN-1:0] md, input logic we,
                                               input logic [4:0] wa, input logic [XLEN-1:0] wd);
    if (src != 5'd0 && me && ma == src) return md;
    if (src != 5'd0 && we && wa == src) return wd;
    return rf;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(reg_read_addr1_e, reg_readdata1_e, fwd_mem_en, fwd_mem_addr, fwd_mem_data,
                    fwd_wb_en, fwd_wb_addr, fwd_wb_data);
    fwd_b = fwd_sel(reg_read_addr2_e, reg_readdata2_e, fwd_mem_en, fwd_mem_addr, fwd_mem_data,
                    fwd_wb_en, fwd_wb_addr, fwd_wb_data);
    op_a  = fwd_a;
    op_b  = alu_mul_data2_sel_e ? imm_data_e : fwd_b;
  end

  // Branch codes 10..15 produce only the condition; their ALU value is 0.
  always_comb begin
    alu_res = '0;
    cond    = 1'b0;
    if (alu_en_e) begin
      case (alu_op_e)
        5'd0:  alu_res = op_a + op_b;
        5'd1:  alu_res = op_a - op_b;
        5'd2:  alu_res = op_a << op_b[4:0];
        5'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
        5'd4:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
        5'd5:  alu_res = op_a ^ op_b;
        5'd6:  alu_res = op_a >> op_b[4:0];
        5'd7:  alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
        5'd8:  alu_res = op_a | op_b;
        5'd9:  alu_res = op_a & op_b;
        5'd10: cond = (op_a == op_b);
        5'd11: cond = (op_a != op_b);
        5'd12: cond = ($signed(op_a) <  $signed(op_b));
        5'd13: cond = ($signed(op_a) >= $signed(op_b));
        5'd14: cond = (op_a <  op_b);
        5'd15: cond = (op_a >= op_b);
        5'd16: alu_res = op_b;
        default: alu_res = '0;
      endcase
    end
  end

  always_comb begin
    pc_sum = (pcadder_in1_sel_e ? fwd_a : pc_e) + (pcadder_in2_sel_e ? XLEN'(4) : imm_data_e);
    if (pcadder_out_merge_sel_e) pc_sum[0] = 1'b0;
  end

  // Multiplier next-state: operands are latched as magnitudes, sign applied in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    var_d    = var_q;
    a_signed = (alu_op_e[1:0] != 2'd3);
    b_signed = (alu_op_e[1:0] == 2'd0) || (alu_op_e[1:0] == 2'd1);
    case (state_q)
      S_IDLE: if (mul_en_e) begin
        mcand_d  = {{XLEN{1'b0}}, abs_val(op_a, a_signed)};
        mplier_d = abs_val(op_b, b_signed);
        sign_d   = (a_signed & op_a[XLEN-1]) ^ (b_signed & op_b[XLEN-1]);
        var_d    = alu_op_e[1:0];
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = S_BUSY;
      end
      S_BUSY: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    sign_q   <= sign_d;
    var_q    <= var_d;
  end

  always_comb begin
    prod    = sign_q ? (~acc_q + 1'b1) : acc_q;
    mul_res = '0;
    if (state_q == S_DONE && mul_en_e)
      mul_res = (var_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    stall_x          = !reset && ((state_q == S_IDLE && mul_en_e) || state_q == S_BUSY);
    reg_write_en_x   = !reset && reg_write_en_e && !stall_x;
    reg_write_addr_x = reg_write_addr_e;
    redirect_x       = !reset && alu_en_e && !stall_x && (pcadder_out_sel_e || cond);
    redirect_pc_x    = pc_sum;
    store_data_x     = fwd_b;
    case (execute_out_sel_e)
      2'd0:    ex_result_x = alu_res;
      2'd1:    ex_result_x = mul_res;
      2'd2:    ex_result_x = pc_sum;
      default: ex_result_x = pc_e + XLEN'(4);
    endcase
  end

endmodule
